tmds_channel_receiver: RTL and testbench

//  Receive-side counterpart of the DVI TX path: one TMDS channel. Takes raw 10-bit words from a
//  1:10 deserializer at arbitrary bit phase, finds the symbol boundary from control-token runs,

---
 rtl/tmds_channel_receiver_pkg.sv | 51 +++++
 rtl/tmds_channel_receiver_aligner.sv | 110 +++++++++++
 rtl/tmds_channel_receiver.sv | 63 ++++++
 tb/tb_tmds_channel_receiver.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_channel_receiver_pkg.sv
// rtl/tmds_channel_receiver_pkg.sv - shared TMDS token constants, alignment FSM states and decode helpers
//
// Purpose: definitions shared by the word aligner and the channel receiver top.
//   TOKEN_xx       10-bit control tokens (bit 9..0), common with the DVI encoder side
//   align_state_t  aligner FSM states (SEARCH=0, LOCKED=1)
//   match_token()  recognises a control token and returns its 2-bit control value
//   tmds_decode()  inverts the TMDS 8b/10b data transform
package tmds_channel_receiver_pkg;

  localparam logic [9:0] TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_11 = 10'b1010101011;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } align_state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] ctrl;
  } token_match_t;

  function automatic token_match_t match_token(input logic [9:0] word);
    token_match_t m;
    m = '0;
    case (word)
      TOKEN_00: m = '{hit: 1'b1, ctrl: 2'b00};
      TOKEN_01: m = '{hit: 1'b1, ctrl: 2'b01};
      TOKEN_10: m = '{hit: 1'b1, ctrl: 2'b10};
      TOKEN_11: m = '{hit: 1'b1, ctrl: 2'b11};
      default:  m = '0;
    endcase
    return m;
  endfunction

  // q[9] marks an inverted payload, q[8] selects XOR (1) or XNOR (0) chaining.
  function automatic logic [7:0] tmds_decode(input logic [9:0] q);
    logic [7:0] d;
    logic [7:0] out;
    d      = q[9] ? ~q[7:0] : q[7:0];
    out    = '0;
    out[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      out[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return out;
  endfunction

endpackage

// File: rtl/tmds_channel_receiver_aligner.sv
// rtl/tmds_channel_receiver_aligner.sv - bit-phase search and symbol alignment for one TMDS channel
//
// Purpose: selects the 10-bit symbol boundary out of two consecutive deserializer words and
//   tracks lock from runs of control tokens.
// Ports:
//   i_clk      pixel clock
//   i_rst_n    synchronous active-low reset
//   i_raw      deserialized word, bit 0 earliest
//   o_aligned  registered aligned symbol (one clock after the word holding its first bit)
//   o_locked   registered lock flag
//   o_offset   current bit offset 0..9
module tmds_channel_receiver_aligner #(
  parameter int LOCK_COUNT   = 8,
  parameter int DWELL_CYCLES = 2048
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [9:0] i_raw,
  output logic [9:0] o_aligned,
  output logic       o_locked,
  output logic [3:0] o_offset
);
  import tmds_channel_receiver_pkg::*;

  localparam int TIMER_W = $clog2(DWELL_CYCLES);
  localparam int RUN_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DWELL_CYCLES - 1);
  localparam logic [RUN_W-1:0]   RUN_LOCK   = RUN_W'(LOCK_COUNT);

  logic [9:0]         raw_q;
  logic [18:0]        window;
  logic [9:0]         aligned;
  align_state_t       state;
  logic [RUN_W-1:0]   run;
  // Dwell counter in SEARCH, no-token watchdog in LOCKED.
  logic [TIMER_W-1:0] timer;
  logic               hit;

  // Offset 9 reaches bit 18 at most, so the newest word's top bit never enters the window.
  assign window = {i_raw[8:0], raw_q};
  assign hit    = match_token(o_aligned).hit;

  always_comb begin
    aligned = raw_q;
    case (o_offset)
      4'd1:    aligned = window[10:1];
      4'd2:    aligned = window[11:2];
      4'd3:    aligned = window[12:3];
      4'd4:    aligned = window[13:4];
      4'd5:    aligned = window[14:5];
      4'd6:    aligned = window[15:6];
      4'd7:    aligned = window[16:7];
      4'd8:    aligned = window[17:8];
      4'd9:    aligned = window[18:9];
      default: aligned = raw_q;
    endcase
  end

  // Terminal counts are tested before incrementing, so run and timer stop at their
  // terminal values instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      raw_q     <= '0;
      o_aligned <= '0;
      state     <= ST_SEARCH;
      run       <= '0;
      timer     <= '0;
      o_locked  <= 1'b0;
      o_offset  <= '0;
    end else begin
      raw_q     <= i_raw;
      o_aligned <= aligned;
      case (state)
        ST_SEARCH: begin
          if (run == RUN_LOCK) begin
            // Checked ahead of dwell expiry so a simultaneous expiry keeps the offset.
            state    <= ST_LOCKED;
            o_locked <= 1'b1;
            run      <= '0;
            timer    <= '0;
          end else if (timer == TIMER_LAST) begin
            o_offset <= (o_offset == 4'd9) ? 4'd0 : o_offset + 4'd1;
            run      <= '0;
            timer    <= '0;
          end else begin
            run   <= hit ? run + 1'b1 : '0;
            timer <= timer + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (timer == TIMER_LAST) begin
            state    <= ST_SEARCH;
            o_locked <= 1'b0;
            run      <= '0;
            timer    <= '0;
          end else begin
            timer <= hit ? '0 : timer + 1'b1;
          end
        end
        default: begin
          state    <= ST_SEARCH;
          o_locked <= 1'b0;
          run      <= '0;
          timer    <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tmds_channel_receiver.sv
// rtl/tmds_channel_receiver.sv - one TMDS receive channel: alignment, token match and data decode
//
// Purpose: turns arbitrary-phase 10-bit deserializer words into DE / 8-bit data / 2-bit control.
//   Input word sampled at edge n reaches the outputs after edge n+2.
// Ports:
//   i_clk     pixel clock
//   i_rst_n   synchronous active-low reset
//   i_raw     deserialized word, bit 0 earliest, unknown bit phase
//   o_de      1 = o_data carries a data symbol
//   o_data    decoded pixel byte
//   o_ctrl    control bits of the last token, held through data
//   o_locked  symbol alignment achieved
//   o_offset  current bit offset (debug)
module tmds_channel_receiver #(
  parameter int LOCK_COUNT   = 8,
  parameter int DWELL_CYCLES = 2048
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [9:0] i_raw,
  output logic       o_de,
  output logic [7:0] o_data,
  output logic [1:0] o_ctrl,
  output logic       o_locked,
  output logic [3:0] o_offset
);
  import tmds_channel_receiver_pkg::*;

  logic [9:0]   aligned;
  token_match_t tok;

  tmds_channel_receiver_aligner #(
    .LOCK_COUNT  (LOCK_COUNT),
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_aligner (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_raw    (i_raw),
    .o_aligned(aligned),
    .o_locked (o_locked),
    .o_offset (o_offset)
  );

  assign tok = match_token(aligned);

  // Gated by the registered lock flag, so the first word after lock follows o_locked.
  // While unlocked the outputs are held at zero, which also resets the held o_ctrl.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !o_locked) begin
      o_de   <= 1'b0;
      o_data <= '0;
      o_ctrl <= '0;
    end else if (tok.hit) begin
      o_de   <= 1'b0;
      o_data <= '0;
      o_ctrl <= tok.ctrl;
    end else begin
      o_de   <= 1'b1;
      o_data <= tmds_decode(aligned);
    end
  end

endmodule

// File: tb/tb_tmds_channel_receiver.sv
// tb/tb_tmds_channel_receiver.sv - randomized self-checking bench for tmds_channel_receiver
module tb_tmds_channel_receiver;

  localparam int LOCK_COUNT = 8;
  localparam int DWELL      = 2048;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] raw = '0;
  logic       de;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       locked;
  logic [3:0] offset;

  tmds_channel_receiver #(
    .LOCK_COUNT  (LOCK_COUNT),
    .DWELL_CYCLES(DWELL)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_raw   (raw),
    .o_de    (de),
    .o_data  (data),
    .o_ctrl  (ctrl),
    .o_locked(locked),
    .o_offset(offset)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Serial bit stream: symbols pushed LSB first, words popped 10 bits at a time.
  bit         bitq[$];
  int         t = 0;
  int         disparity = 0;
  logic       last_locked = 1'b0;
  logic [1:0] model_ctrl = 2'b00;
  logic       r_rst[4];
  logic       r_tok[4];
  logic [1:0] r_ctrl[4];
  logic [7:0] r_byte[4];
  int         bpos = 0;
  logic [1:0] blank_ctrl = 2'b00;

  function automatic logic [9:0] tok_code(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  // Reference DVI 8b/10b encoder with running disparity.
  task automatic encode(input logic [7:0] d, output logic [9:0] q);
    int n1d, n1q, n0q;
    logic [8:0] qm;
    logic xn;
    n1d = $countones(d);
    xn = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~xn;
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (disparity == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      disparity += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((disparity > 0 && n1q > n0q) || (disparity < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      disparity += (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      disparity += (qm[8] ? 0 : -2) + n1q - n0q;
    end
  endtask

  // Checks the outputs left by edge t against the symbol whose first bit was in word t-2.
  task automatic check_edge();
    logic [10:0] exp;
    int k;
    k = (t + 2) % 4;
    if (r_rst[t % 4]) begin
      check("rst_out", {locked, offset, de, ctrl, data}, 32'h0);
      last_locked = 1'b0;
      model_ctrl  = 2'b00;
    end else begin
      if (!last_locked) begin
        exp = '0;
        model_ctrl = 2'b00;
      end else if (r_tok[k]) begin
        model_ctrl = r_ctrl[k];
        exp = {1'b0, r_ctrl[k], 8'h00};
      end else begin
        exp = {1'b1, model_ctrl, r_byte[k]};
      end
      check("out", {de, ctrl, data}, exp);
      last_locked = locked;
    end
  endtask

  task automatic cycle(input logic [9:0] code, input logic tok, input logic [1:0] c,
                       input logic [7:0] b, input logic rst);
    logic [9:0] w;
    @(negedge clk);
    check_edge();
    t++;
    r_rst[t % 4]  = rst;
    r_tok[t % 4]  = tok;
    r_ctrl[t % 4] = c;
    r_byte[t % 4] = b;
    if (rst) begin
      rst_n = 1'b0;
      raw   = 10'($urandom);
    end else begin
      for (int i = 0; i < 10; i++) bitq.push_back(code[i]);
      for (int i = 0; i < 10; i++) w[i] = bitq.pop_front();
      rst_n = 1'b1;
      raw   = w;
    end
  endtask

  task automatic send_reset(input int n);
    repeat (n) cycle(10'h0, 1'b0, 2'b00, 8'h00, 1'b1);
  endtask

  task automatic start_stream(input int p);
    bitq.delete();
    for (int i = 0; i < p; i++) bitq.push_back(1'($urandom));
    disparity = 0;
  endtask

  task automatic send_tok(input logic [1:0] c);
    disparity = 0;
    cycle(tok_code(c), 1'b1, c, 8'h00, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] q;
    encode(b, q);
    cycle(q, 1'b0, 2'b00, b, 1'b0);
  endtask

  // Video-like stream: 160 blanking tokens followed by 40 data symbols.
  task automatic blank_step();
    if (bpos % 200 == 0) blank_ctrl = 2'($urandom);
    if (bpos % 200 < 160) send_tok(blank_ctrl);
    else send_byte(8'($urandom));
    bpos++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      r_rst[i] = 1'b1; r_tok[i] = 1'b0; r_ctrl[i] = 2'b00; r_byte[i] = 8'h00;
    end

    // Reset with random input, then offset-0 lock from exactly 8 tokens.
    send_reset(4);
    start_stream(0);
    repeat (8) send_tok(2'b00);
    repeat (3) cycle(10'h255, 1'b0, 2'b00, 8'h00, 1'b0);
    check("lock_early", locked, 0);
    cycle(10'h255, 1'b0, 2'b00, 8'h00, 1'b0);
    check("lock_edge", locked, 1);
    cycle(10'h255, 1'b0, 2'b00, 8'h00, 1'b0);
    check("data255_de", de, 1);
    check("data255_val", data, 8'h00);
    check("offset0", offset, 0);

    // Control token sequence and hold through data.
    send_tok(2'b00); send_tok(2'b01); send_tok(2'b10); send_tok(2'b11);
    send_byte(8'($urandom)); send_byte(8'($urandom));
    check("ctrl_10", ctrl, 2'b10);
    send_byte(8'($urandom));
    check("ctrl_11", ctrl, 2'b11);
    check("ctrl_de", de, 0);
    send_byte(8'($urandom)); send_byte(8'($urandom));
    check("ctrl_hold", ctrl, 2'b11);
    check("ctrl_hold_de", de, 1);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) send_tok(2'($urandom));
      else send_byte(8'($urandom));
    end

    // Bit phase 3: search through offsets 0..2 then lock.
    send_reset(3);
    start_stream(3);
    bpos = 0;
    for (int i = 0; i < 3 * DWELL + LOCK_COUNT + 2 + 200 && !locked; i++) blank_step();
    check("lock_p3", locked, 1);
    check("offset_p3", offset, 3);
    repeat (700) blank_step();

    // Loss of lock after a long token-free stretch, then relock at the same phase.
    repeat (2000) send_byte(8'($urandom));
    check("wd_hold", locked, 1);
    repeat (100) send_byte(8'($urandom));
    check("wd_drop", locked, 0);
    check("wd_de", de, 0);
    check("wd_data", data, 0);
    check("wd_offset", offset, 3);
    bpos = 0;
    for (int i = 0; i < 40 && !locked; i++) blank_step();
    check("relock", locked, 1);
    check("relock_offset", offset, 3);
    repeat (50) blank_step();

    // Offset walk with no tokens: 9 then wrap to 0.
    send_reset(2);
    start_stream($urandom_range(0, 9));
    repeat (9 * DWELL + 1024) send_byte(8'($urandom));
    check("offset9", offset, 9);
    repeat (DWELL) send_byte(8'($urandom));
    check("offset_wrap", offset, 0);
    check("nolock", locked, 0);

    // Reset while locked returns to SEARCH.
    send_reset(2);
    start_stream(0);
    repeat (12) send_tok(2'($urandom));
    check("pre_rst_lock", locked, 1);
    send_reset(1);
    send_reset(1);
    check("rst_locked", locked, 0);
    check("rst_offset", offset, 0);
    start_stream(0);
    repeat (11) send_tok(2'($urandom));
    check("search_after_rst", locked, 0);
    send_tok(2'($urandom));
    check("relock_after_rst", locked, 1);
    repeat (10) send_byte(8'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
